// File: rtl/out_reg_serializer.sv
// Output-direction IO cell: serializes a fabric word LSB-first onto the pad,
// with registered pad enable, ready/valid handshake and a combinational bypass.
module out_reg_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter int unsigned TAIL       = 1
) (
    input  logic             OQC,
    input  logic             QRT,
    input  logic             OSEL,
    input  logic [WIDTH-1:0] F2A_DATA,
    input  logic             F2A_VALID,
    input  logic             F2A_OE,
    output logic             F2A_READY,
    output logic             OQZ,
    output logic             OEN_Z,
    output logic             BUSY
);

    localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned TAIL_W = 3;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [TAIL_W-1:0] TAIL_LOAD = (TAIL > 0) ? TAIL_W'(TAIL - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_TAIL  = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [WIDTH-1:0]    shreg_q,    shreg_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
    logic                oe_q,       oe_d;
    logic                oqz_q,      oqz_d;
    logic                oen_q,      oen_d;
    logic                ready_state;
    logic                do_load;
    logic                go_idle;

    // State and datapath registers
    always_ff @(posedge OQC) begin
        if (QRT) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            tail_cnt_q <= '0;
            oe_q       <= 1'b0;
            oqz_q      <= IDLE_LEVEL;
            oen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            oe_q       <= oe_d;
            oqz_q      <= oqz_d;
            oen_q      <= oen_d;
        end
    end

    // Next-state: a load reuses the same path from IDLE, last SHIFT bit and TAIL
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;
        oe_d       = oe_q;
        oqz_d      = oqz_q;
        oen_d      = oen_q;
        do_load    = 1'b0;
        go_idle    = 1'b0;

        if (OSEL) begin
            go_idle = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    do_load = F2A_VALID;
                end
                S_SHIFT: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (F2A_VALID) begin
                            do_load = 1'b1;
                        end else if (TAIL > 0) begin
                            state_d    = S_TAIL;
                            tail_cnt_d = TAIL_LOAD;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        oqz_d     = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                S_TAIL: begin
                    if (F2A_VALID) begin
                        do_load = 1'b1;
                    end else if (tail_cnt_q == '0) begin
                        go_idle = 1'b1;
                    end else begin
                        tail_cnt_d = tail_cnt_q - TAIL_W'(1);
                    end
                end
                default: begin
                    go_idle = 1'b1;
                end
            endcase
        end

        if (do_load) begin
            state_d    = S_SHIFT;
            shreg_d    = F2A_DATA;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
            oe_d       = F2A_OE;
            oqz_d      = F2A_DATA[0];
            oen_d      = F2A_OE;
        end

        if (go_idle) begin
            state_d    = S_IDLE;
            shreg_d    = '0;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
            oqz_d      = IDLE_LEVEL;
            oen_d      = 1'b0;
        end
    end

    // Outputs: handshake from state only, bypass muxes the pad-side pair
    always_comb begin
        ready_state = (state_q == S_IDLE) || (state_q == S_TAIL) ||
                      ((state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT));
        F2A_READY   = OSEL | ready_state;
        OQZ         = OSEL ? F2A_DATA[0] : oqz_q;
        OEN_Z       = OSEL ? F2A_OE : oen_q;
        BUSY        = (state_q == S_SHIFT) || (state_q == S_TAIL);
    end

endmodule

// File: tb/tb_out_reg_serializer.sv
// Self-checking bench for out_reg_serializer: vector table with a scoreboard
// queue, plus a hand-written bypass sequence. Two instances: TAIL=1 and TAIL=0.
module tb_out_reg_serializer;

    logic       OQC;
    logic       QRT;
    logic       OSEL;
    logic [3:0] F2A_DATA;
    logic       F2A_VALID;
    logic       F2A_OE;
    logic       rdy, oqz, oen, busy;
    logic       rdy0, oqz0, oen0, busy0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         phase;
        string      name;
        bit         sel;
        bit         qrt;
        bit         valid;
        logic [3:0] data;
        bit         oe;
        bit         chk_rdy;
        bit         exp_rdy;
        bit         exp_oqz;
        bit         exp_oen;
        bit         exp_busy;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    out_reg_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0), .TAIL(1)) u_dut (
        .OQC(OQC), .QRT(QRT), .OSEL(OSEL), .F2A_DATA(F2A_DATA),
        .F2A_VALID(F2A_VALID), .F2A_OE(F2A_OE), .F2A_READY(rdy),
        .OQZ(oqz), .OEN_Z(oen), .BUSY(busy)
    );

    out_reg_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0), .TAIL(0)) u_dut_t0 (
        .OQC(OQC), .QRT(QRT), .OSEL(OSEL), .F2A_DATA(F2A_DATA),
        .F2A_VALID(F2A_VALID), .F2A_OE(F2A_OE), .F2A_READY(rdy0),
        .OQZ(oqz0), .OEN_Z(oen0), .BUSY(busy0)
    );

    initial begin
        OQC = 1'b0;
        forever #5 OQC = ~OQC;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // An accepted transfer must never carry unknown data
    always @(posedge OQC) begin
        if (F2A_VALID === 1'b1 && rdy === 1'b1 && OSEL === 1'b0)
            assert (!$isunknown(F2A_DATA)) else $error("unknown data on accepted transfer");
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input int ph, input string nm, input bit sel, input bit qrt,
                       input bit vld, input logic [3:0] d, input bit oe, input bit chk,
                       input bit r, input bit q, input bit e, input bit b);
        vec_t v;
        v.phase = ph; v.name = nm; v.sel = sel; v.qrt = qrt; v.valid = vld;
        v.data = d; v.oe = oe; v.chk_rdy = chk; v.exp_rdy = r;
        v.exp_oqz = q; v.exp_oen = e; v.exp_busy = b;
        tbl.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge OQC);
        QRT = v.qrt; F2A_VALID = v.valid; F2A_DATA = v.data; F2A_OE = v.oe; OSEL = 1'b0;
        sb.push_back(v);
        #1;
        if (v.chk_rdy) check({v.name, ".ready"}, v.sel ? rdy0 : rdy, v.exp_rdy);
        @(posedge OQC);
        #1;
        e = sb.pop_front();
        check({e.name, ".oqz"},  e.sel ? oqz0  : oqz,  e.exp_oqz);
        check({e.name, ".oen"},  e.sel ? oen0  : oen,  e.exp_oen);
        check({e.name, ".busy"}, e.sel ? busy0 : busy, e.exp_busy);
    endtask

    task automatic run_phase(input int ph);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].phase == ph) run_vec(tbl[i]);
    endtask

    initial begin
        QRT = 1'b1; OSEL = 1'b0; F2A_VALID = 1'b0; F2A_DATA = 4'h0; F2A_OE = 1'b0;

        //  ph name           sel qrt vld data  oe chk rdy oqz oen busy
        add(0, "rst",         0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        add(0, "single_b0",   0, 0, 1, 4'hB, 1, 1, 1, 1, 1, 1);
        add(0, "single_b1",   0, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(0, "single_b2",   0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, "single_b3",   0, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(0, "single_tail", 0, 0, 0, 4'h0, 0, 1, 1, 1, 1, 1);
        add(0, "single_idle", 0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(0, "idle",        0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(0, "b2b_0",       0, 0, 1, 4'hA, 1, 1, 1, 0, 1, 1);
        add(0, "b2b_1",       0, 0, 1, 4'h5, 1, 1, 0, 1, 1, 1);
        add(0, "b2b_2",       0, 0, 1, 4'h5, 1, 1, 0, 0, 1, 1);
        add(0, "b2b_3",       0, 0, 1, 4'h5, 1, 1, 0, 1, 1, 1);
        add(0, "b2b_4",       0, 0, 1, 4'h5, 1, 1, 1, 1, 1, 1);
        add(0, "b2b_5",       0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, "b2b_6",       0, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(0, "b2b_7",       0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, "b2b_tail",    0, 0, 0, 4'h0, 0, 1, 1, 0, 1, 1);
        add(0, "b2b_idle",    0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(0, "oe_0",        0, 0, 1, 4'hF, 0, 1, 1, 1, 0, 1);
        add(0, "oe_1",        0, 0, 0, 4'h0, 0, 1, 0, 1, 0, 1);
        add(0, "oe_2",        0, 0, 0, 4'h0, 0, 1, 0, 1, 0, 1);
        add(0, "oe_3",        0, 0, 0, 4'h0, 0, 1, 0, 1, 0, 1);
        add(0, "oe_4",        0, 0, 1, 4'h0, 1, 1, 1, 0, 1, 1);
        add(0, "oe_5",        0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, "oe_6",        0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, "oe_7",        0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, "oe_tail",     0, 0, 0, 4'h0, 0, 1, 1, 0, 1, 1);
        add(0, "oe_idle",     0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(0, "rmw_0",       0, 0, 1, 4'hC, 1, 1, 1, 0, 1, 1);
        add(0, "rmw_1",       0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(0, "rmw_rst",     0, 1, 1, 4'h5, 1, 1, 0, 0, 0, 0);
        add(0, "rmw_after",   0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(1, "pre_rst",     0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        add(1, "pre_w",       0, 0, 1, 4'hB, 1, 1, 1, 1, 1, 1);
        add(1, "pre_s",       0, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(2, "post_0",      0, 0, 1, 4'h6, 1, 1, 1, 0, 1, 1);
        add(2, "post_1",      0, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(2, "post_2",      0, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(2, "post_3",      0, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(2, "post_tail",   0, 0, 0, 4'h0, 0, 1, 1, 0, 1, 1);
        add(2, "post_idle",   0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(3, "t0_rst",      1, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        add(3, "t0_a0",       1, 0, 1, 4'h9, 1, 1, 1, 1, 1, 1);
        add(3, "t0_a1",       1, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(3, "t0_a2",       1, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(3, "t0_a3",       1, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(3, "t0_b0",       1, 0, 1, 4'h6, 1, 1, 1, 0, 1, 1);
        add(3, "t0_b1",       1, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(3, "t0_b2",       1, 0, 0, 4'h0, 0, 1, 0, 1, 1, 1);
        add(3, "t0_b3",       1, 0, 0, 4'h0, 0, 1, 0, 0, 1, 1);
        add(3, "t0_drop",     1, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);
        add(3, "t0_idle",     1, 0, 0, 4'h0, 0, 1, 1, 0, 0, 0);

        run_phase(0);
        run_phase(1);

        // Bypass entered mid-word: pad pair follows fabric combinationally
        @(negedge OQC);
        OSEL = 1'b1; F2A_VALID = 1'b1; F2A_DATA = 4'h0; F2A_OE = 1'b0;
        #1;
        check("byp_oqz0",  oqz,  1'b0);
        check("byp_oen0",  oen,  1'b0);
        check("byp_ready", rdy,  1'b1);
        check("byp_busy_before_edge", busy, 1'b1);
        F2A_DATA = 4'h1; F2A_OE = 1'b1;
        #1;
        check("byp_oqz1", oqz, 1'b1);
        check("byp_oen1", oen, 1'b1);
        F2A_DATA = 4'hE;
        #1;
        check("byp_oqz2", oqz, 1'b0);
        @(posedge OQC);
        #1;
        check("byp_busy_after_edge", busy, 1'b0);
        check("byp_oen_after_edge",  oen,  1'b1);
        @(posedge OQC);
        #1;
        check("byp_not_captured", busy, 1'b0);
        @(negedge OQC);
        OSEL = 1'b0; F2A_VALID = 1'b0; F2A_DATA = 4'h0; F2A_OE = 1'b0;
        #1;
        check("byp_exit_oqz",   oqz,  1'b0);
        check("byp_exit_oen",   oen,  1'b0);
        check("byp_exit_ready", rdy,  1'b1);
        check("byp_exit_busy",  busy, 1'b0);

        run_phase(2);
        run_phase(3);

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
